acc_mem_responder: RTL and testbench
====================================

Name: acc_mem_responder

Overview:
- Responder end of the accelerator memory bus: addr/dataR/dataW/en/we.
- Single-port 32-bit word memory holding the input image (words 0..IMG_WORDS-1) and the result image (words IMG_WORDS..2*IMG_WORDS-1).
- Returns read data with a fixed 1-cycle latency, which is the only timing the accelerator tolerates.
- Also drives the start/finish handshake toward the accelerator and gives a host port for image load/unload while the accelerator is idle.

Parameters:
- IMG_WORDS, 25344, words per image (288*352/4).
- DEPTH, 50688, memory depth in words (2*IMG_WORDS).
- TIMEOUT, 262143, max cycles in S_RUN before forced abort; 0 disables the check.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  16  accelerator word address.
- dataR  out  32  read data to the accelerator.
- dataW  in  32  write data from the accelerator.
- en  in  1  accelerator access request.
- we  in  1  accelerator write enable (1 = write).
- start  out  1  start to the accelerator.
- finish  in  1  finish from the accelerator.
- run  in  1  host pulse to launch a job.
- busy  out  1  job in progress (S_RUN or S_DONE).
- done  out  1  1-cycle pulse when a job completes.
- host_en  in  1  host access request.
- host_we  in  1  host write enable.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data.
- host_rvalid  out  1  host read data valid.
- err  out  3  sticky flags: [0] out-of-range, [1] protocol, [2] timeout.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=S_IDLE; start, busy, done, host_rvalid = 0; dataR, host_rdata = 0; err=0; timeout counter = 0. Memory contents are not cleared.
- Sequencer FSM:
  - S_IDLE: start=0. run=1 moves to S_RUN next cycle.
  - S_RUN: start=1, busy=1; the timeout counter increments every cycle. finish=1 moves to S_DONE. If TIMEOUT!=0 and the counter reaches TIMEOUT, move to S_DONE and set err[2].
  - S_DONE: start=0, busy=1. Wait for finish=0, then move to S_IDLE with done=1 for exactly that transition cycle. The timeout counter clears on entry to S_IDLE.
  - run while busy=1 is ignored.
- Accelerator bus (honoured only in S_RUN):
  - Read (en=1, we=0 at edge N): dataR = mem[addr] registered at edge N, so it is valid during cycle N+1. dataR holds until the next accepted read.
  - Write (en=1, we=1 at edge N): mem[addr] <= dataW at edge N. A read issued at edge N+1 to the same address returns the new value.
  - en=0: no access; dataR holds.
  - en=1 outside S_RUN: ignored and sets err[1].
- Host port (honoured only in S_IDLE):
  - Read: same 1-cycle latency as the accelerator; host_rvalid=1 for exactly one cycle with host_rdata. host_rdata holds afterwards.
  - Write: commits at the edge.
  - host_en=1 while busy: ignored, host_rvalid stays 0, sets err[1].
- Range check (both ports): addr>=DEPTH.
  - A write is dropped.
  - A read returns 32'h0 (host_rvalid still pulses for a host read).
  - Either sets err[0].
- Sticky flags: err bits clear only on reset or on the S_IDLE->S_RUN transition.
- Widths: addresses are compared unsigned at 16 bits; no wrap-around. Memory indexing uses $clog2(DEPTH) bits after the range check.
- Reset mid-job: start drops in the cycle after the reset edge; the FSM returns to S_IDLE. Any access sampled in the same cycle as reset is discarded.

Optional Feature:
- Macro: ACC_MEM_STATS_EN.
- When defined, adds outputs rd_count[15:0] and wr_count[15:0].
  - They count accepted in-range accelerator reads and writes.
  - They clear on reset and on S_IDLE->S_RUN, saturate at 16'hFFFF, and hold after the job.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Host write 32'h11223344 to word 5, then host read word 5 -> host_rvalid=1 exactly one cycle later, host_rdata=32'h11223344, err=0.
- run pulse; in S_RUN, accelerator read of word 5 at edge N -> dataR=32'h11223344 in cycle N+1. Write 32'hEEDDCCBB to word 25349, then read it next cycle -> dataR=32'hEEDDCCBB.
- Accelerator raises finish -> start=0 next cycle. finish low -> done=1 for one cycle, busy=0. With ACC_MEM_STATS_EN: rd_count=2, wr_count=1.
- Accelerator read of addr=50688 in S_RUN -> dataR=0, err[0]=1. host_en=1 during S_RUN -> no host_rvalid, err[1]=1.
- TIMEOUT=16, finish held 0 -> S_DONE after 16 cycles in S_RUN, err[2]=1, start=0. Then done pulses one cycle later (finish=0).
- reset=1 for one cycle mid-S_RUN -> start=0, busy=0, err=0 next cycle. Word 5 still reads 32'h11223344 via the host port.

Source files
------------

// File: rtl/acc_mem_if.sv
// acc_mem_if: accelerator-side memory bus plus the start/finish handshake.
//   addr   [15:0]  word address from the accelerator
//   dataR  [31:0]  read data returned one cycle after the request
//   dataW  [31:0]  write data from the accelerator
//   en             access request
//   we             write enable (1 = write)
//   start          job start toward the accelerator
//   finish         job finish from the accelerator
// Modports: master = accelerator side, slave = memory responder side.
interface acc_mem_if;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic        start;
  logic        finish;

  modport master (output addr, dataW, en, we, finish, input dataR, start);
  modport slave  (input addr, dataW, en, we, finish, output dataR, start);
endinterface

// File: rtl/acc_mem_responder.sv
// acc_mem_responder: single-port 32-bit word memory answering the accelerator
// bus with a fixed 1-cycle read latency, a start/finish job sequencer, and a
// host port for loading/unloading images while the accelerator is idle.
// Words 0..IMG_WORDS-1 hold the input image, IMG_WORDS..2*IMG_WORDS-1 the result.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus (slave)         accelerator bus: addr/dataR/dataW/en/we, start/finish
//   run                 host pulse launching a job (ignored while busy)
//   busy                job in progress (S_RUN or S_DONE)
//   done                1-cycle pulse on the S_DONE -> S_IDLE transition
//   host_en/host_we     host access request / write enable (S_IDLE only)
//   host_addr/host_wdata host word address / write data
//   host_rdata/host_rvalid host read data, valid for one cycle
//   err[2:0]            sticky: [0] out-of-range, [1] protocol, [2] timeout
//
// Optional feature (macro ACC_MEM_STATS_EN): adds rd_count/wr_count, saturating
// counts of accepted in-range accelerator reads/writes for the current job.
module acc_mem_responder #(
  parameter int IMG_WORDS = 25344,
  parameter int DEPTH     = 2 * IMG_WORDS,
  parameter int TIMEOUT   = 262143
) (
  input  logic        clk,
  input  logic        reset,
  acc_mem_if.slave    bus,
  input  logic        run,
  output logic        busy,
  output logic        done,
  input  logic        host_en,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  output logic [2:0]  err
`ifdef ACC_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam bit          TMO_EN  = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   mem [DEPTH];

  logic          acc_acc;
  logic          host_acc;
  logic [15:0]   mem_addr;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   rd_word;

  // The two requesters are never honoured in the same state, so one shared
  // address/data path serves both.
  always_comb begin
    acc_acc   = (state == S_RUN) && bus.en;
    host_acc  = (state == S_IDLE) && host_en;
    mem_addr  = acc_acc ? bus.addr : host_addr;
    mem_wdata = acc_acc ? bus.dataW : host_wdata;
    in_range  = ({1'b0, mem_addr} < DEPTH_L);
    mem_idx   = mem_addr[AW-1:0];
    rd_word   = in_range ? mem[mem_idx] : 32'h0;
    // Accesses sampled together with reset are discarded.
    mem_we    = !reset && in_range &&
                ((acc_acc && bus.we) || (host_acc && host_we));
  end

  // Memory array (no reset: contents survive reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  // Sequencer, read-data registers and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bus.start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      host_rvalid <= 1'b0;
      bus.dataR   <= 32'h0;
      host_rdata  <= 32'h0;
      err         <= 3'b000;
      tmo_cnt     <= '0;
`ifdef ACC_MEM_STATS_EN
      rd_count    <= 16'h0;
      wr_count    <= 16'h0;
`endif
    end else begin
      done        <= 1'b0;
      host_rvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state     <= S_RUN;
            bus.start <= 1'b1;
            busy      <= 1'b1;
            err       <= 3'b000;
            tmo_cnt   <= '0;
`ifdef ACC_MEM_STATS_EN
            rd_count  <= 16'h0;
            wr_count  <= 16'h0;
`endif
          end
        end
        S_RUN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (bus.finish) begin
            state     <= S_DONE;
            bus.start <= 1'b0;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            // Counter reaches TIMEOUT on this edge: abort the job.
            state     <= S_DONE;
            bus.start <= 1'b0;
            err[2]    <= 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.finish) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus.start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      if (acc_acc) begin
        if (!in_range) err[0] <= 1'b1;
        if (!bus.we) bus.dataR <= rd_word;
      end
      if (bus.en && (state != S_RUN)) err[1] <= 1'b1;

      if (host_acc) begin
        if (!in_range) err[0] <= 1'b1;
        if (!host_we) begin
          host_rdata  <= rd_word;
          host_rvalid <= 1'b1;
        end
      end
      if (host_en && (state != S_IDLE)) err[1] <= 1'b1;

`ifdef ACC_MEM_STATS_EN
      if (acc_acc && in_range) begin
        if (bus.we) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'h1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'h1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_acc_mem_responder.sv
module tb_acc_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        busy;
  logic        done;
  logic        host_en;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic [2:0]  err;
`ifdef ACC_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_host[$];
  logic [31:0] exp_acc[$];

  acc_mem_if bus ();

  acc_mem_responder #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .run         (run),
    .busy        (busy),
    .done        (done),
    .host_en     (host_en),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .err         (err)
`ifdef ACC_MEM_STATS_EN
    ,
    .rd_count    (rd_count),
    .wr_count    (wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Host read monitor: every host_rvalid pulse consumes one expected word.
  always @(negedge clk) begin
    if (host_rvalid === 1'b1) begin
      if (exp_host.size() == 0) chk("host_rv_unexpected", {31'b0, host_rvalid}, 32'd0);
      else chk("host_rdata", host_rdata, exp_host.pop_front());
    end
  end

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_en = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [15:0] a, input logic [31:0] e);
    host_en = 1'b1; host_we = 1'b0; host_addr = a;
    exp_host.push_back(e);
    @(negedge clk);
    host_en = 1'b0;
    @(negedge clk);
    chk("host_rv_one_cycle", {31'b0, host_rvalid}, 32'd0);
    chk("host_rd_seen", exp_host.size(), 32'd0);
    chk("host_rdata_hold", host_rdata, e);
  endtask

  task automatic acc_rd(input logic [15:0] a, input logic [31:0] e);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = a;
    exp_acc.push_back(e);
    @(negedge clk);
    bus.en = 1'b0;
    chk("acc_dataR", bus.dataR, exp_acc.pop_front());
  endtask

  task automatic acc_wr(input logic [15:0] a, input logic [31:0] d);
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = a; bus.dataW = d;
    @(negedge clk);
    bus.en = 1'b0; bus.we = 1'b0;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; run = 1'b0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    bus.addr = '0; bus.dataW = '0; bus.en = 1'b0; bus.we = 1'b0; bus.finish = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_start", {31'b0, bus.start}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rvalid", {31'b0, host_rvalid}, 32'd0);
    chk("rst_dataR", bus.dataR, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_err", {29'b0, err}, 32'd0);

    // Host load and readback
    host_wr(16'd5, 32'h11223344);
    host_rd(16'd5, 32'h11223344);
    chk("host_err", {29'b0, err}, 32'd0);

    // Job 1: normal accelerator traffic
    pulse_run();
    chk("run_start", {31'b0, bus.start}, 32'd1);
    chk("run_busy", {31'b0, busy}, 32'd1);
    acc_rd(16'd5, 32'h11223344);
    acc_wr(16'd25349, 32'hEEDDCCBB);
    acc_rd(16'd25349, 32'hEEDDCCBB);
    @(negedge clk);
    chk("acc_dataR_hold", bus.dataR, 32'hEEDDCCBB);
    bus.finish = 1'b1;
    @(negedge clk);
    chk("fin_start", {31'b0, bus.start}, 32'd0);
    chk("fin_busy", {31'b0, busy}, 32'd1);
    chk("fin_done", {31'b0, done}, 32'd0);
    bus.finish = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
`ifdef ACC_MEM_STATS_EN
    chk("rd_count", {16'b0, rd_count}, 32'd2);
    chk("wr_count", {16'b0, wr_count}, 32'd1);
`endif
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("job1_err", {29'b0, err}, 32'd0);

    // Job 2: out-of-range read and host access while busy
    pulse_run();
    acc_rd(16'd50688, 32'h0);
    chk("oor_err", {29'b0, err}, 32'd1);
    host_en = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    @(negedge clk);
    host_en = 1'b0;
    chk("busy_host_rv", {31'b0, host_rvalid}, 32'd0);
    @(negedge clk);
    chk("busy_host_rv2", {31'b0, host_rvalid}, 32'd0);
    chk("proto_err", {29'b0, err}, 32'd3);
`ifdef ACC_MEM_STATS_EN
    chk("rd_count_oor", {16'b0, rd_count}, 32'd0);
`endif
    bus.finish = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    repeat (2) @(negedge clk);

    // Job 3: timeout with finish held low
    pulse_run();
    chk("err_clear_on_run", {29'b0, err}, 32'd0);
    cnt = 0;
    while (bus.start === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_cycles", cnt, 32'd16);
    chk("tmo_start", {31'b0, bus.start}, 32'd0);
    chk("tmo_busy", {31'b0, busy}, 32'd1);
    chk("tmo_err", {29'b0, err}, 32'd4);
    @(negedge clk);
    chk("tmo_done", {31'b0, done}, 32'd1);
    chk("tmo_done_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);

    // Job 4: reset mid-run, with a write sampled alongside reset
    pulse_run();
    acc_rd(16'd50688, 32'h0);
    reset = 1'b1;
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = 16'd5; bus.dataW = 32'hDEADBEEF;
    @(negedge clk);
    reset = 1'b0; bus.en = 1'b0; bus.we = 1'b0;
    chk("mrst_start", {31'b0, bus.start}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_err", {29'b0, err}, 32'd0);
    host_rd(16'd5, 32'h11223344);

    // Accelerator request while idle is ignored and flagged
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = 16'd5;
    @(negedge clk);
    bus.en = 1'b0;
    chk("idle_en_err", {29'b0, err}, 32'd2);
    chk("idle_en_dataR", bus.dataR, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
